// File: rtl/ls_gate_pipe_n.sv
// Bank of CHANNELS 2-input gates sharing one run-time function, followed by a
// clock-enabled register pipeline STAGES deep with a saturating fill counter.
module ls_gate_pipe_n #(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                flush,
  input  logic [2:0]          fn,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  input  logic                oe,
  output logic [CHANNELS-1:0] y,
  output logic                vld
);

  localparam int FW = $clog2(STAGES + 1);

  typedef enum logic [2:0] {
    FN_OR   = 3'b000,
    FN_NOR  = 3'b001,
    FN_AND  = 3'b010,
    FN_NAND = 3'b011,
    FN_XOR  = 3'b100,
    FN_XNOR = 3'b101,
    FN_A    = 3'b110,
    FN_NA   = 3'b111
  } gate_fn_e;

  gate_fn_e            fn_sel;
  logic [CHANNELS-1:0] gate_y;
  logic [CHANNELS-1:0] pipe [STAGES];
  logic [FW-1:0]       fill;

  assign fn_sel = gate_fn_e'(fn);

  // NOTE: combinational block assigns a default first so no path can infer a latch.
  always_comb begin
    gate_y = '0;
    case (fn_sel)
      FN_OR:   gate_y = a | b;
      FN_NOR:  gate_y = ~(a | b);
      FN_AND:  gate_y = a & b;
      FN_NAND: gate_y = ~(a & b);
      FN_XOR:  gate_y = a ^ b;
      FN_XNOR: gate_y = ~(a ^ b);
      FN_A:    gate_y = a;
      FN_NA:   gate_y = ~a;
      default: gate_y = '0;
    endcase
  end

  // NOTE: non-blocking assignments let pipe[i] take the pre-edge pipe[i-1];
  // the pipeline array is reset explicitly because Y must read zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      fill <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      fill <= '0;
    end else if (ce) begin
      pipe[0] <= gate_y;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      if (fill != FW'(STAGES)) fill <= fill + FW'(1);
    end
  end

  // Output enable gates only the visible result, never the stored data.
  assign y   = oe ? pipe[STAGES-1] : '0;
  assign vld = (fill == FW'(STAGES));

endmodule

// File: tb/tb_ls_gate_pipe_n.sv
// Directed bench: one single-stage and one three-stage instance share the
// same stimulus; each step checks hand-computed outputs.
module tb_ls_gate_pipe_n;

  logic       clk = 1'b0;
  logic       rst, ce, flush, oe;
  logic [2:0] fn;
  logic [3:0] a, b;
  logic [3:0] y1, y3;
  logic       vld1, vld3;

  int n_pass  = 0;
  int n_total = 0;

  ls_gate_pipe_n #(.CHANNELS(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .fn(fn),
    .a(a), .b(b), .oe(oe), .y(y1), .vld(vld1)
  );

  ls_gate_pipe_n #(.CHANNELS(4), .STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .fn(fn),
    .a(a), .b(b), .oe(oe), .y(y3), .vld(vld3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 4'hE; sweep_exp[1] = 4'h1; sweep_exp[2] = 4'h8; sweep_exp[3] = 4'h7;
    sweep_exp[4] = 4'h6; sweep_exp[5] = 4'h9; sweep_exp[6] = 4'hC; sweep_exp[7] = 4'h3;

    rst = 1'b1; ce = 1'b0; flush = 1'b0; oe = 1'b1;
    fn = 3'b000; a = 4'h0; b = 4'h0;
    #12;
    check("reset_y1", 32'(y1), 32'h0);
    check("reset_vld1", 32'(vld1), 32'h0);
    check("reset_y3", 32'(y3), 32'h0);
    check("reset_vld3", 32'(vld3), 32'h0);
    rst = 1'b0;

    // Function sweep on the single-stage instance.
    ce = 1'b1; a = 4'b1100; b = 4'b1010;
    for (int f = 0; f < 8; f++) begin
      fn = 3'(f);
      step();
      check($sformatf("sweep_fn%0d", f), 32'(y1), 32'(sweep_exp[f]));
    end
    check("sweep_vld1", 32'(vld1), 32'h1);

    // Latency on the three-stage instance.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("lat_flush_vld3", 32'(vld3), 32'h0);
    fn = 3'b000; a = 4'h1; b = 4'h0;
    step();
    check("lat_e1_y3", 32'(y3), 32'h0);
    check("lat_e1_y1", 32'(y1), 32'h1);
    a = 4'h0;
    step();
    check("lat_e2_y3", 32'(y3), 32'h0);
    check("lat_e2_vld3", 32'(vld3), 32'h0);
    step();
    check("lat_e3_y3", 32'(y3), 32'h1);
    check("lat_e3_vld3", 32'(vld3), 32'h1);
    step();
    check("lat_e4_y3", 32'(y3), 32'h0);

    // Stall: stream 1,2,3 with CE low for four edges after the second sample.
    flush = 1'b1;
    step();
    flush = 1'b0;
    a = 4'h1;
    step();
    a = 4'h2;
    step();
    check("stall_pre_vld3", 32'(vld3), 32'h0);
    ce = 1'b0; a = 4'h3;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stall%0d_y3", i), 32'(y3), 32'h0);
      check($sformatf("stall%0d_vld3", i), 32'(vld3), 32'h0);
      check($sformatf("stall%0d_y1", i), 32'(y1), 32'h2);
    end
    ce = 1'b1;
    step();
    check("resume_e3_y3", 32'(y3), 32'h1);
    check("resume_e3_vld3", 32'(vld3), 32'h1);
    a = 4'h0;
    step();
    check("resume_e4_y3", 32'(y3), 32'h2);
    step();
    check("resume_e5_y3", 32'(y3), 32'h3);

    // Mid-stream function change: the value already in flight keeps its old function.
    fn = 3'b011; a = 4'hF; b = 4'hF;     // NAND -> 0
    step();
    fn = 3'b001; a = 4'h0; b = 4'h0;     // NOR -> F
    step();
    fn = 3'b110; a = 4'h5;               // A -> 5
    step();
    check("fnchg_y3_nand", 32'(y3), 32'h0);
    step();
    check("fnchg_y3_nor", 32'(y3), 32'hF);
    step();
    check("fnchg_y3_a", 32'(y3), 32'h5);

    // Flush beats CE with a full pipe; the input on that edge must not be captured.
    fn = 3'b000; a = 4'hF; b = 4'h0;
    check("flush_pre_vld3", 32'(vld3), 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0; a = 4'h0;
    check("flush_y3", 32'(y3), 32'h0);
    check("flush_vld3", 32'(vld3), 32'h0);
    check("flush_y1", 32'(y1), 32'h0);
    check("flush_vld1", 32'(vld1), 32'h0);
    step();
    step();
    check("flush_nocap_y3", 32'(y3), 32'h0);
    check("flush_nocap_vld3", 32'(vld3), 32'h0);

    // Output enable with 5 held in the single-stage pipe.
    a = 4'h5; b = 4'h0;
    step();
    check("oe_load_y1", 32'(y1), 32'h5);
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      oe = 1'b0;
      #1;
      check($sformatf("oe%0d_off_y1", i), 32'(y1), 32'h0);
      check($sformatf("oe%0d_off_vld1", i), 32'(vld1), 32'h1);
      oe = 1'b1;
      #1;
      check($sformatf("oe%0d_on_y1", i), 32'(y1), 32'h5);
    end
    oe = 1'b0;
    step();
    oe = 1'b1;
    #1;
    check("oe_hold_y1", 32'(y1), 32'h5);

    // Asynchronous reset mid-stream with Y = F.
    ce = 1'b1; fn = 3'b000; a = 4'hF; b = 4'h0;
    step();
    step();
    step();
    check("rst_pre_y1", 32'(y1), 32'hF);
    check("rst_pre_y3", 32'(y3), 32'hF);
    #2 rst = 1'b1;
    #1;
    check("rst_async_y1", 32'(y1), 32'h0);
    check("rst_async_vld1", 32'(vld1), 32'h0);
    check("rst_async_y3", 32'(y3), 32'h0);
    check("rst_async_vld3", 32'(vld3), 32'h0);
    step();
    rst = 1'b0;
    step();
    check("rst_rel_y1", 32'(y1), 32'hF);
    check("rst_rel_vld3", 32'(vld3), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
